// File: rtl/br_resolve_pkg.sv
// Shared branch-resolution constants: control-word type codes, prediction-tag
// bit positions and the predictor-update record layout.
package br_resolve_pkg;

  localparam logic [3:0] TYPE_BR  = 4'd1;
  localparam logic [3:0] TYPE_JMP = 4'd8;

  localparam int CTR_TYPE_MSB  = 3;
  localparam int CTR_SUB_LSB   = 7;
  localparam int CTR_SUB_MSB   = 11;

  localparam int PRE_W         = 76;
  localparam int PRE_TGT_MSB   = 31;
  localparam int PRE_TAKEN     = 33;
  localparam int PRE_NPC       = 34;
  localparam int PRE_TWOLEVEL  = 38;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  localparam int UPD_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mis;
  } upd_entry_t;

  localparam int UPD_W = $bits(upd_entry_t);

  function automatic logic is_branch(input logic [3:0] typ);
    return (typ == TYPE_BR) || (typ == TYPE_JMP);
  endfunction

endpackage

// File: rtl/br_resolve_upd_fifo.sv
// Small synchronous FIFO buffering predictor updates; a push into a full FIFO
// is accepted only when the head pops in the same cycle, otherwise it is dropped.
module upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign o_valid   = (r_count != {(AW+1){1'b0}});
  assign o_data    = r_mem[r_rptr];
  assign w_full    = (r_count == CNT_FULL);
  assign w_pop     = o_valid & i_ready;
  assign w_push_ok = i_push & (~w_full | w_pop);
  assign o_drop    = i_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wptr <= (r_wptr == PTR_LAST) ? {AW{1'b0}} : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_LAST) ? {AW{1'b0}} : r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/br_resolve.sv
// EX-stage branch resolution: detects mispredicts, issues a registered flush and
// redirect, squashes wrong-path instructions and queues predictor updates.
module br_resolve
  import br_resolve_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [31:0]       ctr,
  input  logic [31:0]       pc,
  input  logic              ifbr,
  input  logic [31:0]       brresult,
  input  logic [PRE_W-1:0]  pre,
  input  logic              upd_ready,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic              upd_valid,
  output logic [31:0]       upd_pc,
  output logic [31:0]       upd_target,
  output logic              upd_taken,
  output logic              upd_mis,
  output logic [31:0]       br_cnt,
  output logic [31:0]       mis_cnt,
  output logic [31:0]       drop_cnt
);

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic        r_flush;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;
  logic [31:0] r_drop_cnt;

  logic        w_is_br;
  logic        w_match;
  logic        w_resolve;
  logic        w_mis_raw;
  logic        w_mis;
  logic        w_push;
  logic [31:0] w_target;
  logic        w_fifo_valid;
  logic        w_fifo_drop;
  logic [UPD_W-1:0] w_fifo_data;
  upd_entry_t  w_entry;
  upd_entry_t  w_head;
  logic        w_unused;

  assign w_is_br   = is_branch(ctr[CTR_TYPE_MSB:0]);
  // In SQUASH only the instruction at the redirect target may resolve.
  assign w_match   = ex_valid & (pc == r_redirect_pc);
  assign w_resolve = ex_valid & ~ex_stall & ((r_state == ST_RUN) | w_match);
  assign w_mis_raw = w_is_br ? ((ifbr != pre[PRE_TAKEN]) |
                                (ifbr & (brresult != pre[PRE_TGT_MSB:0])))
                             : pre[PRE_TAKEN];
  assign w_mis     = w_resolve & w_mis_raw;
  assign w_push    = w_resolve & w_is_br;
  assign w_target  = (ifbr & w_is_br) ? brresult : pc + 32'd4;

  assign w_entry = '{pc: pc, target: w_target, taken: ifbr, mis: w_mis_raw};
  assign w_head  = upd_entry_t'(w_fifo_data);

  // Subtype and the remaining prediction-tag fields are consumed by other stages.
  assign w_unused = ^{ctr[31:CTR_TYPE_MSB+1], pre[PRE_W-1:PRE_TAKEN+1], pre[32]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_mis) w_state_nxt = ST_SQUASH;
        else       w_state_nxt = ST_RUN;
      end
      ST_SQUASH: begin
        if (w_match) w_state_nxt = w_mis ? ST_SQUASH : ST_RUN;
        else         w_state_nxt = ST_SQUASH;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_flush       <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_br_cnt      <= 32'd0;
      r_mis_cnt     <= 32'd0;
      r_drop_cnt    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_flush    <= w_mis;
      if (w_mis) begin
        r_redirect_pc <= w_target;
      end
      r_br_cnt   <= r_br_cnt   + {31'd0, w_push};
      r_mis_cnt  <= r_mis_cnt  + {31'd0, w_mis};
      r_drop_cnt <= r_drop_cnt + {31'd0, w_fifo_drop};
    end
  end

  upd_fifo #(
    .DEPTH (UPD_DEPTH),
    .WIDTH (UPD_W)
  ) u_upd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_ready (upd_ready),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_drop  (w_fifo_drop)
  );

  // Head fields are forced to zero while the FIFO is empty.
  assign upd_valid   = w_fifo_valid;
  assign upd_pc      = w_fifo_valid ? w_head.pc     : 32'd0;
  assign upd_target  = w_fifo_valid ? w_head.target : 32'd0;
  assign upd_taken   = w_fifo_valid & w_head.taken;
  assign upd_mis     = w_fifo_valid & w_head.mis;

  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign br_cnt      = r_br_cnt;
  assign mis_cnt     = r_mis_cnt;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: a resolve-sequence table plus hand-written
// sequences for FIFO backpressure, stalls and reset during SQUASH.
module tb_br_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall;
  logic [31:0] ctr, pc, brresult;
  logic        ifbr;
  logic [75:0] pre;
  logic        upd_ready;
  logic        flush, upd_valid, upd_taken, upd_mis;
  logic [31:0] redirect_pc, upd_pc, upd_target, br_cnt, mis_cnt, drop_cnt;

  int checks = 0;
  int failures = 0;

  br_resolve dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ctr(ctr), .pc(pc), .ifbr(ifbr), .brresult(brresult), .pre(pre),
    .upd_ready(upd_ready), .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mis(upd_mis), .br_cnt(br_cnt),
    .mis_cnt(mis_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, st; logic [3:0] ty; logic [31:0] pc; logic ifbr;
    logic [31:0] br; logic ptk; logic [31:0] ptgt;
    logic e_flush; logic [31:0] e_rpc; logic e_uv;
    logic [31:0] e_upc, e_utgt; logic e_utk, e_umis;
    logic [31:0] e_brc, e_misc;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(
      input logic v, st, input logic [3:0] ty, input logic [31:0] p,
      input logic ib, input logic [31:0] br, input logic ptk, input logic [31:0] ptgt,
      input logic ef, input logic [31:0] erpc, input logic euv,
      input logic [31:0] eupc, eutgt, input logic eutk, eumis,
      input logic [31:0] ebrc, emisc);
    vec_t r;
    r.v = v; r.st = st; r.ty = ty; r.pc = p; r.ifbr = ib; r.br = br;
    r.ptk = ptk; r.ptgt = ptgt; r.e_flush = ef; r.e_rpc = erpc; r.e_uv = euv;
    r.e_upc = eupc; r.e_utgt = eutgt; r.e_utk = eutk; r.e_umis = eumis;
    r.e_brc = ebrc; r.e_misc = emisc;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, st, input logic [3:0] ty, input logic [31:0] p,
                       input logic ib, input logic [31:0] br, input logic ptk,
                       input logic [31:0] ptgt);
    ex_valid = v; ex_stall = st; ctr = {28'd0, ty}; pc = p;
    ifbr = ib; brresult = br; pre = {42'd0, ptk, 1'b0, ptgt};
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] exp_a[4];

  initial begin
    rst = 1'b1; upd_ready = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);

    tbl[0]  = mk(1,0,4'd1,32'h1000,1,32'h1040,1,32'h1040, 0,32'h0,   1,32'h1000,32'h1040,1,0, 1,0);
    tbl[1]  = mk(1,0,4'd1,32'h1000,1,32'h1040,0,32'h0,    1,32'h1040,1,32'h1000,32'h1040,1,1, 2,1);
    tbl[2]  = mk(1,0,4'd1,32'h1004,1,32'h1100,0,32'h0,    0,32'h0,   0,32'h0,32'h0,0,0,       2,1);
    tbl[3]  = mk(1,0,4'd8,32'h1040,1,32'h2000,1,32'h2000, 0,32'h0,   1,32'h1040,32'h2000,1,0, 3,1);
    tbl[4]  = mk(1,0,4'd0,32'h2000,0,32'h0,   1,32'h2400, 1,32'h2004,0,32'h0,32'h0,0,0,       3,2);
    tbl[5]  = mk(1,0,4'd0,32'h2004,0,32'h0,   0,32'h0,    0,32'h0,   0,32'h0,32'h0,0,0,       3,2);
    tbl[6]  = mk(1,0,4'd1,32'h3000,1,32'h3100,1,32'h3200, 1,32'h3100,1,32'h3000,32'h3100,1,1, 4,3);
    tbl[7]  = mk(0,0,4'd1,32'h3100,0,32'h0,   1,32'h0,    0,32'h0,   0,32'h0,32'h0,0,0,       4,3);
    tbl[8]  = mk(1,1,4'd1,32'h3100,0,32'h0,   1,32'h0,    0,32'h0,   0,32'h0,32'h0,0,0,       4,3);
    tbl[9]  = mk(1,0,4'd1,32'h3100,0,32'h0,   1,32'h0,    1,32'h3104,1,32'h3100,32'h3104,0,1, 5,4);
    tbl[10] = mk(1,0,4'd1,32'h3104,0,32'h0,   0,32'h0,    0,32'h0,   1,32'h3104,32'h3108,0,0, 6,4);
    tbl[11] = mk(1,0,4'd0,32'hFFFFFFFC,0,32'h0,1,32'h0,   1,32'h0,   0,32'h0,32'h0,0,0,       6,5);
    tbl[12] = mk(1,0,4'd0,32'h0,   0,32'h0,   0,32'h0,    0,32'h0,   0,32'h0,32'h0,0,0,       6,5);

    do_reset();
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_uvalid", {31'd0, upd_valid}, 32'd0);
    chk("rst_brcnt", br_cnt, 32'd0);
    chk("rst_miscnt", mis_cnt, 32'd0);
    chk("rst_dropcnt", drop_cnt, 32'd0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].ty, tbl[i].pc, tbl[i].ifbr, tbl[i].br,
            tbl[i].ptk, tbl[i].ptgt);
      tick();
      chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, tbl[i].e_flush});
      if (tbl[i].e_flush) chk($sformatf("v%0d_rpc", i), redirect_pc, tbl[i].e_rpc);
      chk($sformatf("v%0d_uvalid", i), {31'd0, upd_valid}, {31'd0, tbl[i].e_uv});
      if (tbl[i].e_uv) begin
        chk($sformatf("v%0d_upc", i), upd_pc, tbl[i].e_upc);
        chk($sformatf("v%0d_utgt", i), upd_target, tbl[i].e_utgt);
        chk($sformatf("v%0d_utaken", i), {31'd0, upd_taken}, {31'd0, tbl[i].e_utk});
        chk($sformatf("v%0d_umis", i), {31'd0, upd_mis}, {31'd0, tbl[i].e_umis});
      end
      chk($sformatf("v%0d_brcnt", i), br_cnt, tbl[i].e_brc);
      chk($sformatf("v%0d_miscnt", i), mis_cnt, tbl[i].e_misc);
    end

    // Backpressure: five pushes into a 4-deep FIFO, then push+pop while full.
    do_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 4'd1, 32'h100 + 32'(4*i), 0, 32'h0, 0, 32'h0);
      tick();
    end
    chk("bp_uvalid", {31'd0, upd_valid}, 32'd1);
    chk("bp_drop", drop_cnt, 32'd1);
    chk("bp_brcnt", br_cnt, 32'd5);
    chk("bp_head", upd_pc, 32'h100);
    upd_ready = 1'b1;
    drive(1, 0, 4'd1, 32'h200, 0, 32'h0, 0, 32'h0);
    tick();
    chk("full_pp_drop", drop_cnt, 32'd1);
    chk("full_pp_brcnt", br_cnt, 32'd6);
    drive(0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'h0);
    exp_a[0] = 32'h104; exp_a[1] = 32'h108; exp_a[2] = 32'h10C; exp_a[3] = 32'h200;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), {31'd0, upd_valid}, 32'd1);
      chk($sformatf("drain%0d_pc", i), upd_pc, exp_a[i]);
      chk($sformatf("drain%0d_tgt", i), upd_target, exp_a[i] + 32'd4);
      tick();
    end
    chk("drain_empty", {31'd0, upd_valid}, 32'd0);

    // Stalled branch resolves once, when released.
    do_reset();
    upd_ready = 1'b0;
    drive(1, 1, 4'd1, 32'h400, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_brcnt", i), br_cnt, 32'd0);
      chk($sformatf("stall%0d_uvalid", i), {31'd0, upd_valid}, 32'd0);
    end
    ex_stall = 1'b0;
    tick();
    chk("rel_brcnt", br_cnt, 32'd1);
    chk("rel_uvalid", {31'd0, upd_valid}, 32'd1);
    chk("rel_upc", upd_pc, 32'h400);
    drive(0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    chk("rel_hold_brcnt", br_cnt, 32'd1);
    upd_ready = 1'b1;
    tick();
    chk("rel_popped", {31'd0, upd_valid}, 32'd0);

    // Reset while squashing with a full FIFO.
    do_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 4'd1, 32'h600 + 32'(4*i), 0, 32'h0, 0, 32'h0);
      tick();
    end
    drive(1, 0, 4'd1, 32'h60C, 1, 32'h700, 0, 32'h0);
    tick();
    chk("sq_flush", {31'd0, flush}, 32'd1);
    chk("sq_rpc", redirect_pc, 32'h700);
    chk("sq_miscnt", mis_cnt, 32'd1);
    rst = 1'b1;
    drive(1, 0, 4'd0, 32'h700, 0, 32'h0, 1, 32'h0);
    tick();
    rst = 1'b0;
    chk("sqrst_flush", {31'd0, flush}, 32'd0);
    chk("sqrst_rpc", redirect_pc, 32'd0);
    chk("sqrst_uvalid", {31'd0, upd_valid}, 32'd0);
    chk("sqrst_upc", upd_pc, 32'd0);
    chk("sqrst_brcnt", br_cnt, 32'd0);
    chk("sqrst_miscnt", mis_cnt, 32'd0);
    chk("sqrst_dropcnt", drop_cnt, 32'd0);
    drive(1, 0, 4'd1, 32'h500, 0, 32'h0, 0, 32'h0);
    tick();
    chk("post_uvalid", {31'd0, upd_valid}, 32'd1);
    chk("post_upc", upd_pc, 32'h500);
    chk("post_brcnt", br_cnt, 32'd1);
    chk("post_flush", {31'd0, flush}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 ex_valid  in  1  EX-stage instruction valid this cycle.
REQ-004 ex_stall  in  1  EX held; the instruction presented this cycle is not resolved.
REQ-005 ctr  in  32  decoded control word: type=ctr[3:0], subtype=ctr[11:7].
REQ-006 pc  in  32  EX instruction PC.
REQ-007 ifbr  in  1  actual taken from branch ALU.
REQ-008 brresult  in  32  actual target from branch ALU.
REQ-009 pre  in  76  prediction tag: pre[31:0] predicted target, pre[33] predicted taken, pre[34] NPC-level prediction, pre[38] two-level flag.
REQ-010 upd_ready  in  1  predictor accepts an update.
REQ-011 flush  out  1  registered one-cycle front-end flush pulse.
REQ-012 redirect_pc  out  32  correct fetch PC; valid while flush=1.
REQ-013 upd_valid  out  1  update FIFO head valid.
REQ-014 upd_pc, upd_target  out  32 each  update PC and resolved target.
REQ-015 upd_taken, upd_mis  out  1 each  resolved direction; mispredict flag.
REQ-016 br_cnt, mis_cnt, drop_cnt  out  32 each  resolved-branch, mispredict and dropped-update counters.

Function
REQ-017 Resolve event: ex_valid & ~ex_stall & state==RUN.
REQ-018 is_br = (type==1) | (type==8).
REQ-019 Mispredict on resolve: is_br & (ifbr != pre[33] | (ifbr & brresult != pre[31:0])); also ~is_br & pre[33].
REQ-020 Correct target: ifbr&is_br ? brresult : pc+4, 32-bit wrap-around.
REQ-021 flush and redirect_pc are driven from registers one cycle after the mispredicting resolve; flush is high for exactly one cycle.
REQ-022 FSM RUN: a mispredict moves the FSM to SQUASH.
REQ-023 FSM SQUASH: no resolves; returns to RUN on the cycle in which ex_valid & pc==redirect_pc holds, and that instruction resolves in the same cycle.
REQ-024 Every is_br resolve pushes {pc, correct target, ifbr, mispredict} into a 4-entry FIFO.
REQ-025 FIFO head is presented on upd_*; it pops when upd_valid & upd_ready.
REQ-026 Simultaneous push and pop on a full FIFO succeeds.
REQ-027 Push to a full FIFO without a pop drops the new entry and increments drop_cnt.
REQ-028 br_cnt increments per is_br resolve; mis_cnt increments per mispredict; all counters wrap at 2^32.
REQ-029 Only ex_valid & ~ex_stall resolves count; a stalled instruction resolves once, when released.

Reset
REQ-030 On rst: flush=0, redirect_pc=0, FSM=RUN, FIFO empty (upd_valid=0), all counters 0; rst overrides any same-cycle resolve.
REQ-031 rst asserted while in SQUASH returns the FSM to RUN with no pending flush.

Structure
REQ-032 Type codes (BR=1, JMP=8) and pre[] bit positions are shared package constants, reused by the branch ALU.
REQ-033 The FIFO is one sub-module, upd_fifo, parameterised by depth (default 4) and width.

Verification
REQ-034 BEQ, pc=0x1000, ifbr=1, brresult=0x1040, pre taken to 0x1040 -> no flush; FIFO entry {0x1000, 0x1040, 1, 0}; br_cnt=1.
REQ-035 Same branch with pre[33]=0 -> next cycle flush=1 and redirect_pc=0x1040; SQUASH ignores pc=0x1004; resolves pc=0x1040; mis_cnt=1.
REQ-036 Non-branch at pc=0x2000 with pre[33]=1 -> flush; redirect_pc=0x2004; no FIFO push.
REQ-037 upd_ready=0 with 5 branch resolves -> 4 entries held, drop_cnt=1; raise upd_ready -> drains in order.
REQ-038 ex_stall=1 for 3 cycles on a branch -> exactly one push and br_cnt+1.
REQ-039 rst in SQUASH with a full FIFO -> all outputs 0; next branch resolves normally.
